// File: rtl/flicky_snd_cmd_tx.sv
// Main-CPU side of the sound-command link: queues command bytes and sends each one to the
// sound board as sndno plus a timed sndstart pulse, with setup, hold and spacing guaranteed.
module flicky_snd_cmd_tx #(
  parameter int DEPTH_LOG2 = 2,
  parameter int SETUP_CYC  = 2,
  parameter int HOLD_CYC   = 16,
  parameter int GAP_CYC    = 4000
) (
  input  logic                  clk8M,
  input  logic                  reset,
  input  logic                  cmd_wr,
  input  logic [7:0]            cmd_data,
  input  logic                  flush,
  input  logic                  ovf_clr,
  output logic [7:0]            sndno,
  output logic                  sndstart,
  output logic                  busy,
  output logic                  fifo_full,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic                  overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {IDLE, SETUP, ASSERT, GAP} state_t;

  state_t                state;
  logic [15:0]           cnt;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   level;
  logic                  pop;
  logic                  wr_acc;
  logic                  wr_drop;

  // A flush on the pop edge empties the queue before anything is launched.
  assign pop     = (state == IDLE) && (level != '0) && !flush;
  assign wr_acc  = cmd_wr && !flush && (!fifo_full || pop);
  assign wr_drop = cmd_wr && !flush && fifo_full && !pop;

  assign fifo_full  = (level == LVL_FULL);
  assign fifo_level = level;
  assign busy       = (state != IDLE);

  // NOTE: the storage array has no reset; only entries counted by level are ever read.
  always_ff @(posedge clk8M) begin
    if (wr_acc) mem[wr_ptr] <= cmd_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk8M or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)    rd_ptr <= rd_ptr + PTR_ONE;
      level <= level + (DEPTH_LOG2+1)'(wr_acc) - (DEPTH_LOG2+1)'(pop);
    end
  end

  // Set wins over clear so a drop coinciding with ovf_clr is never lost.
  always_ff @(posedge clk8M or posedge reset) begin
    if (reset)        overflow <= 1'b0;
    else if (wr_drop) overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

  always_ff @(posedge clk8M or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      sndno    <= '0;
      sndstart <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sndstart <= 1'b0;
          if (pop) begin
            sndno <= mem[rd_ptr];
            cnt   <= 16'(SETUP_CYC - 1);
            state <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            sndstart <= 1'b1;
            cnt      <= 16'(HOLD_CYC - 1);
            state    <= ASSERT;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        ASSERT: begin
          if (cnt == '0) begin
            sndstart <= 1'b0;
            cnt      <= 16'(GAP_CYC - 1);
            state    <= GAP;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        GAP: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
